// File: rtl/blk_6f540a.sv
// ---------------------------------------------------------------------------
// blk_6f540a : OCI debug-memory controller (system-clock domain)
//
// Owns the on-chip debug RAM and services two masters against it:
//   - JTAG, through the wrapper's take_*_ocimem strobes and jdo payload.
//     Supported operations are address load with optional read, write with
//     address increment, and read with address increment.
//   - CPU, through an Avalon-MM slave port. Writes take effect only when
//     debugaccess is set.
// JTAG always wins arbitration. A single pending slot absorbs one JTAG strobe
// that arrives while the RAM is busy.
//
// Ports
//   clk, reset_n             clock, async active-low reset
//   jdo[37:0]                JTAG payload (stable while a strobe is high)
//   take_action_ocimem_a     load MonAReg from jdo[AW+16:17]; read if jdo[35]
//   take_action_ocimem_b     write jdo[34:3] at MonAReg, then increment
//   take_no_action_ocimem_a  read at MonAReg, then increment
//   MonDReg[31:0]            last JTAG read result
//   jtag_overrun             sticky: a JTAG strobe was dropped
//   chipselect/address/read/write/writedata/byteenable/debugaccess
//                            Avalon-MM slave request
//   readdata[31:0]           Avalon read data (valid while waitrequest=0)
//   waitrequest              Avalon stall
// ---------------------------------------------------------------------------
module blk_6f540a #(
  parameter int AW        = 8,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic          take_no_action_ocimem_a,
  output logic [31:0]   MonDReg,
  output logic          jtag_overrun,
  input  logic          chipselect,
  input  logic [AW-1:0] address,
  input  logic          read,
  input  logic          write,
  input  logic [31:0]   writedata,
  input  logic [3:0]    byteenable,
  input  logic          debugaccess,
  output logic [31:0]   readdata,
  output logic          waitrequest
);

  typedef enum logic [2:0] {IDLE, J_RD, J_CAP, A_RD, A_ACK} state_t;
  typedef enum logic [1:0] {K_NONE, K_A, K_B, K_NA} kind_t;

  // The RAM has no reset and no power-up load in this netlist; INIT_FILE is
  // carried for the implementation tool's memory-initialisation flow.
  localparam bit unused_zero_init = (INIT_FILE == "");

  logic unused_jdo;
  assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

  state_t        state, state_nx;
  logic [AW-1:0] MonAReg, mon_a_nx;
  logic [AW-1:0] rd_addr, rd_addr_nx;   // address held through *_RD
  logic [31:0]   rd_hold;               // readdata between Avalon reads

  // pending slot keeps jdo[35:3]: [32]=read flag, [31:0]=write data
  logic          pend_vld;
  kind_t         pend_kind;
  logic [32:0]   pend_jdo;

  // RAM port
  logic [31:0]   mem [2**AW];
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wd;
  logic [31:0]   ram_q;

  kind_t         new_kind, req_kind;
  logic          new_vld, new_multi, in_idle;
  logic          serve_pend, serve_new, latch_new, drop_new;
  logic [32:0]   req_jdo;
  logic [AW-1:0] req_addr;
  logic          av_wr, av_rd, ack;

  // ---------------- strobe decode and arbitration ----------------
  always_comb begin
    new_kind = K_NONE;
    if (take_action_ocimem_b)         new_kind = K_B;
    else if (take_action_ocimem_a)    new_kind = K_A;
    else if (take_no_action_ocimem_a) new_kind = K_NA;
  end

  assign new_multi = (take_action_ocimem_b & take_action_ocimem_a) |
                     (take_action_ocimem_b & take_no_action_ocimem_a) |
                     (take_action_ocimem_a & take_no_action_ocimem_a);
  assign new_vld   = (new_kind != K_NONE);
  assign in_idle   = (state == IDLE);

  // The pending entry is older, so it is serviced first; a strobe arriving
  // in that same cycle refills the slot as it empties.
  assign serve_pend = in_idle & pend_vld;
  assign serve_new  = in_idle & ~pend_vld & new_vld;
  assign latch_new  = new_vld & ~serve_new;
  assign drop_new   = latch_new & pend_vld & ~serve_pend;

  assign req_kind = serve_pend ? pend_kind : (serve_new ? new_kind : K_NONE);
  assign req_jdo  = serve_pend ? pend_jdo : jdo[35:3];
  assign req_addr = req_jdo[AW+13:14];   // jdo[AW+16:17]

  // Avalon is only considered in IDLE cycles with no JTAG work.
  assign av_wr = in_idle & (req_kind == K_NONE) & chipselect & write;
  assign av_rd = in_idle & (req_kind == K_NONE) & chipselect & read & ~write;
  assign ack   = av_wr | (state == A_ACK);

  assign waitrequest = chipselect & (read | write) & ~ack;
  assign readdata    = (state == A_ACK) ? ram_q : rd_hold;

  // ---------------- next state and RAM port ----------------
  always_comb begin
    state_nx   = state;
    mon_a_nx   = MonAReg;
    rd_addr_nx = rd_addr;
    ram_addr   = rd_addr;
    ram_we     = 4'h0;
    ram_wd     = writedata;
    case (state)
      IDLE: begin
        case (req_kind)
          K_B: begin
            ram_addr = MonAReg;
            ram_we   = 4'hF;
            ram_wd   = req_jdo[31:0];
            mon_a_nx = MonAReg + AW'(1);
          end
          K_A: begin
            mon_a_nx = req_addr;
            if (req_jdo[32]) begin
              rd_addr_nx = req_addr;
              state_nx   = J_RD;
            end
          end
          K_NA: begin
            rd_addr_nx = MonAReg;
            mon_a_nx   = MonAReg + AW'(1);
            state_nx   = J_RD;
          end
          default: begin
            if (av_wr) begin
              ram_addr = address;
              ram_we   = byteenable & {4{debugaccess}};
            end else if (av_rd) begin
              rd_addr_nx = address;
              state_nx   = A_RD;
            end
          end
        endcase
      end
      J_RD:    state_nx = J_CAP;
      J_CAP:   state_nx = IDLE;
      A_RD:    state_nx = A_ACK;
      A_ACK:   state_nx = IDLE;   // completes even if chipselect dropped
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- control registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      MonAReg      <= '0;
      rd_addr      <= '0;
      MonDReg      <= '0;
      rd_hold      <= '0;
      jtag_overrun <= 1'b0;
      pend_vld     <= 1'b0;
      pend_kind    <= K_NONE;
      pend_jdo     <= '0;
    end else begin
      state   <= state_nx;
      MonAReg <= mon_a_nx;
      rd_addr <= rd_addr_nx;
      if (state == J_CAP) MonDReg <= ram_q;
      if (state == A_ACK) rd_hold <= ram_q;
      if (drop_new | new_multi) jtag_overrun <= 1'b1;
      if (serve_pend) pend_vld <= 1'b0;
      if (latch_new & ~drop_new) begin
        pend_vld  <= 1'b1;
        pend_kind <= new_kind;
        pend_jdo  <= jdo[35:3];
      end
    end
  end

  // ---------------- single-port RAM, read-before-write ----------------
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wd[8*b +: 8];
    ram_q <= mem[ram_addr];
  end

endmodule

// File: tb/tb_blk_6f540a.sv
module tb_blk_6f540a;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [37:0]   jdo = '0;
  logic          take_action_ocimem_a = 1'b0;
  logic          take_action_ocimem_b = 1'b0;
  logic          take_no_action_ocimem_a = 1'b0;
  logic [31:0]   MonDReg;
  logic          jtag_overrun;
  logic          chipselect = 1'b0;
  logic [AW-1:0] address = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [3:0]    byteenable = '0;
  logic          debugaccess = 1'b0;
  logic [31:0]   readdata;
  logic          waitrequest;

  int pass_cnt = 0;
  int total = 0;

  blk_6f540a #(.AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .MonDReg(MonDReg), .jtag_overrun(jtag_overrun),
    .chipselect(chipselect), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .debugaccess(debugaccess),
    .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] a);
    logic [37:0] d;
    d = '0; d[35] = rd; d[24:17] = a;
    return d;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] w);
    logic [37:0] d;
    d = '0; d[34:3] = w;
    return d;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask = {no_action_a, ocimem_b, ocimem_a}; one-cycle pulse
  task automatic strobe(input logic [2:0] mask, input logic [37:0] d);
    jdo = d;
    take_action_ocimem_a    = mask[0];
    take_action_ocimem_b    = mask[1];
    take_no_action_ocimem_a = mask[2];
    @(negedge clk);
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic av_read(input logic [7:0] a, output logic [31:0] d, output bit ok);
    ok = 1'b0; d = '0;
    chipselect = 1'b1; read = 1'b1; address = a;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (!waitrequest) begin ok = 1'b1; d = readdata; end
      @(negedge clk);
    end
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic av_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic dbg, output int waits);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    byteenable = be; debugaccess = dbg; waits = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!waitrequest) break;
      waits++;
      @(negedge clk);
    end
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; debugaccess = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (MonDReg !== 32'h0) $display("FAIL reset_mondreg got %h want 0", MonDReg); else pass_cnt++;
    total++; if (jtag_overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", jtag_overrun); else pass_cnt++;
    total++; if (readdata !== 32'h0) $display("FAIL reset_readdata got %h want 0", readdata); else pass_cnt++;
    total++; if (waitrequest !== 1'b0) $display("FAIL reset_waitreq got %b want 0", waitrequest); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_jtag_rw();
    strobe(3'b001, jdo_a(1'b0, 8'h10));
    strobe(3'b010, jdo_b(32'hDEADBEEF));
    strobe(3'b001, jdo_a(1'b1, 8'h10));
    cyc(1);
    total++; if (MonDReg !== 32'h0) $display("FAIL jrd_early got %h want 0", MonDReg); else pass_cnt++;
    cyc(1);
    total++; if (MonDReg !== 32'hDEADBEEF) $display("FAIL jrd_data got %h want deadbeef", MonDReg); else pass_cnt++;
    total++; if (dut.MonAReg !== 8'h10) $display("FAIL jrd_addr got %h want 10", dut.MonAReg); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp [3];
    exp[0] = 32'h11111111; exp[1] = 32'h22222222; exp[2] = 32'h33333333;
    strobe(3'b001, jdo_a(1'b0, 8'hFF));
    for (int i = 0; i < 3; i++) strobe(3'b010, jdo_b(exp[i]));
    strobe(3'b001, jdo_a(1'b0, 8'hFF));
    for (int i = 0; i < 3; i++) begin
      strobe(3'b100, '0);
      cyc(3);
      total++; if (MonDReg !== exp[i]) $display("FAIL wrap_rd%0d got %h want %h", i, MonDReg, exp[i]); else pass_cnt++;
    end
    total++; if (dut.MonAReg !== 8'h02) $display("FAIL wrap_addr got %h want 02", dut.MonAReg); else pass_cnt++;
  endtask

  task automatic test_collision();
    logic [31:0] d; bit ok;
    strobe(3'b001, jdo_a(1'b0, 8'h05));
    strobe(3'b010, jdo_b(32'h5A5A0005));
    strobe(3'b001, jdo_a(1'b0, 8'h05));
    chipselect = 1'b1; read = 1'b1; address = 8'h05;
    @(negedge clk);                       // now in A_RD
    total++; if (waitrequest !== 1'b1) $display("FAIL coll_stall got %b want 1", waitrequest); else pass_cnt++;
    jdo = jdo_b(32'hC0FFEE05); take_action_ocimem_b = 1'b1;
    @(negedge clk);                       // now in A_ACK
    take_action_ocimem_b = 1'b0;
    #1;
    total++; if (waitrequest !== 1'b0 || readdata !== 32'h5A5A0005)
      $display("FAIL coll_avrd got wr=%b rd=%h want wr=0 rd=5a5a0005", waitrequest, readdata); else pass_cnt++;
    chipselect = 1'b0; read = 1'b0;
    @(negedge clk);
    total++; if (dut.mem[5] !== 32'h5A5A0005) $display("FAIL coll_early got %h want 5a5a0005", dut.mem[5]); else pass_cnt++;
    @(negedge clk);
    total++; if (dut.mem[5] !== 32'hC0FFEE05) $display("FAIL coll_land got %h want c0ffee05", dut.mem[5]); else pass_cnt++;
    av_read(8'h05, d, ok);
    total++; if (!ok || d !== 32'hC0FFEE05) $display("FAIL coll_readback got %h ok=%0d want c0ffee05", d, ok); else pass_cnt++;
    total++; if (jtag_overrun !== 1'b0) $display("FAIL coll_overrun got %b want 0", jtag_overrun); else pass_cnt++;
  endtask

  task automatic test_byteen();
    logic [31:0] d; bit ok; int w;
    av_write(8'h20, 32'hAAAAAAAA, 4'hF, 1'b1, w);
    av_write(8'h20, 32'h12345678, 4'b0011, 1'b1, w);
    total++; if (w !== 0) $display("FAIL be_wait got %0d want 0", w); else pass_cnt++;
    av_read(8'h20, d, ok);
    total++; if (!ok || d !== 32'hAAAA5678) $display("FAIL be_merge got %h ok=%0d want aaaa5678", d, ok); else pass_cnt++;
    av_write(8'h20, 32'hFFFFFFFF, 4'hF, 1'b0, w);
    total++; if (w !== 0) $display("FAIL nodbg_wait got %0d want 0", w); else pass_cnt++;
    av_read(8'h20, d, ok);
    total++; if (!ok || d !== 32'hAAAA5678) $display("FAIL nodbg_keep got %h ok=%0d want aaaa5678", d, ok); else pass_cnt++;
  endtask

  task automatic test_write_collision();
    logic [31:0] d; bit ok;
    strobe(3'b001, jdo_a(1'b0, 8'h60));
    jdo = jdo_b(32'hBAD0BAD0); take_action_ocimem_b = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 8'h60;
    writedata = 32'h600D600D; byteenable = 4'hF; debugaccess = 1'b1;
    #1;
    total++; if (waitrequest !== 1'b1) $display("FAIL wcoll_stall got %b want 1", waitrequest); else pass_cnt++;
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
    #1;
    total++; if (waitrequest !== 1'b0) $display("FAIL wcoll_accept got %b want 0", waitrequest); else pass_cnt++;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; debugaccess = 1'b0;
    av_read(8'h60, d, ok);
    total++; if (!ok || d !== 32'h600D600D) $display("FAIL wcoll_last got %h ok=%0d want 600d600d", d, ok); else pass_cnt++;
    total++; if (dut.MonAReg !== 8'h61) $display("FAIL wcoll_addr got %h want 61", dut.MonAReg); else pass_cnt++;
  endtask

  task automatic test_overrun();
    strobe(3'b001, jdo_a(1'b0, 8'h40));
    strobe(3'b010, jdo_b(32'h40404040));
    strobe(3'b010, jdo_b(32'h41414141));
    strobe(3'b001, jdo_a(1'b0, 8'h40));
    take_no_action_ocimem_a = 1'b1;
    cyc(3);
    take_no_action_ocimem_a = 1'b0;
    cyc(5);
    total++; if (jtag_overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", jtag_overrun); else pass_cnt++;
    total++; if (dut.MonAReg !== 8'h42) $display("FAIL ovr_addr got %h want 42", dut.MonAReg); else pass_cnt++;
    total++; if (MonDReg !== 32'h41414141) $display("FAIL ovr_data got %h want 41414141", MonDReg); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; bit ok;
    strobe(3'b001, jdo_a(1'b0, 8'h50));
    strobe(3'b010, jdo_b(32'hCAFEF00D));
    strobe(3'b001, jdo_a(1'b1, 8'h50));
    @(negedge clk);
    total++; if (dut.state !== 3'd2) $display("FAIL rst_in_jcap got %0d want 2", dut.state); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total++; if (MonDReg !== 32'h0) $display("FAIL rst_mondreg got %h want 0", MonDReg); else pass_cnt++;
    total++; if (dut.state !== 3'd0) $display("FAIL rst_state got %0d want 0", dut.state); else pass_cnt++;
    total++; if (waitrequest !== 1'b0) $display("FAIL rst_waitreq got %b want 0", waitrequest); else pass_cnt++;
    total++; if (jtag_overrun !== 1'b0) $display("FAIL rst_overrun got %b want 0", jtag_overrun); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    av_read(8'h50, d, ok);
    total++; if (!ok || d !== 32'hCAFEF00D) $display("FAIL rst_ram got %h ok=%0d want cafef00d", d, ok); else pass_cnt++;
  endtask

  task automatic test_multi_strobe();
    strobe(3'b101, jdo_a(1'b0, 8'h30));
    cyc(2);
    total++; if (dut.MonAReg !== 8'h30) $display("FAIL multi_addr got %h want 30", dut.MonAReg); else pass_cnt++;
    total++; if (jtag_overrun !== 1'b1) $display("FAIL multi_overrun got %b want 1", jtag_overrun); else pass_cnt++;
    total++; if (dut.state !== 3'd0) $display("FAIL multi_state got %0d want 0", dut.state); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_jtag_rw();
    test_wrap();
    test_collision();
    test_byteen();
    test_write_collision();
    test_overrun();
    test_reset_mid();
    test_multi_strobe();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
